pipe_wb_arbiter: RTL and testbench

Register-file write-port arbiter between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). The pipeline's writeback request normally owns the single write port. MDU results are parked in a one-entry buffer and drained into idle write slots. A starvation counter forces a one-cycle pipeline stall so a parked result cannot wait forever.

---
 rtl/pipe_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_pipe_wb_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_arbiter.sv
// pipe_wb_arbiter: shares the single register-file write port between the
// pipeline writeback stage and a one-entry buffer of multiply/divide results.
// The pipeline normally owns the port. A parked MDU result drains on idle
// slots. After STARVE_LIMIT consecutive lost cycles it takes the port by
// stalling the pipeline for one cycle.
module pipe_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_rd_waddr,
  input  logic        in_rd_wena,
  input  logic [31:0] in_rd_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        pend_valid,
  output logic [4:0]  pend_waddr,
  output logic [4:0]  out_rd_waddr,
  output logic        out_rd_wena,
  output logic [31:0] out_rd_wdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  // cnt value that, once one more cycle is lost, exhausts the budget.
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    buf_waddr;
  logic [31:0]   buf_wdata;
  logic          sel_buf;
  logic          pipe_wr;
  logic          capture;
  logic [4:0]    sel_waddr;
  logic [31:0]   sel_wdata;
  logic          sel_wena;

  // A pipe write to $0 is treated as no write at all.
  assign pipe_wr = in_rd_wena && (in_rd_waddr != 5'd0);

  // Buffer loads only when it can accept, which is exactly IDLE.
  assign capture = (state == IDLE) && mdu_valid;

  // State, starvation count and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the one-entry buffer is reset too, so a result parked before
      // reset can never reappear on the port or on pend_waddr afterwards.
      state     <= IDLE;
      cnt       <= '0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        buf_waddr <= mdu_waddr;
        buf_wdata <= mdu_wdata;
      end
    end
  end

  // Next-state decode plus Moore handshake/status outputs and port select.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_buf    = 1'b0;
    mdu_ready  = 1'b0;
    pipe_stall = 1'b0;
    pend_valid = 1'b0;
    unique case (state)
      IDLE: begin
        mdu_ready = 1'b1;
        cnt_nxt   = '0;
        // A result aimed at $0 is accepted but never parked.
        if (mdu_valid && (mdu_waddr != 5'd0)) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        pend_valid = 1'b1;
        if (!pipe_wr) begin
          // Free slot: drain the buffer.
          sel_buf   = 1'b1;
          state_nxt = IDLE;
        end else if (in_rd_waddr == buf_waddr) begin
          // Younger pipe write to the same register supersedes the buffer.
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = FORCE;
          end
        end
      end
      FORCE: begin
        // Pipeline is frozen and re-presents its request next cycle, so the
        // buffer writes unconditionally and no kill check applies.
        pend_valid = 1'b1;
        pipe_stall = 1'b1;
        sel_buf    = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign pend_waddr = pend_valid ? buf_waddr : 5'd0;

  assign sel_waddr = sel_buf ? buf_waddr : in_rd_waddr;
  assign sel_wdata = sel_buf ? buf_wdata : in_rd_wdata;
  assign sel_wena  = sel_buf ? 1'b1      : in_rd_wena;

  // The port is combinational from state and in_*, so it is gated by rst
  // directly to stay quiet from the moment reset rises.
  assign out_rd_wena  = !rst && sel_wena && (sel_waddr != 5'd0);
  assign out_rd_waddr = rst ? 5'd0  : sel_waddr;
  assign out_rd_wdata = rst ? 32'd0 : sel_wdata;

endmodule

// File: tb/tb_pipe_wb_arbiter.sv
// Directed bench for pipe_wb_arbiter: one task per scenario, each with its
// own hand-computed expectations. A second instance with STARVE_LIMIT=1
// covers the smallest starvation budget.
module tb_pipe_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_rd_waddr;
  logic        in_rd_wena;
  logic [31:0] in_rd_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;

  logic        mdu_ready, pipe_stall, pend_valid;
  logic [4:0]  pend_waddr, out_rd_waddr;
  logic        out_rd_wena;
  logic [31:0] out_rd_wdata;

  logic        l1_mdu_ready, l1_pipe_stall, l1_pend_valid;
  logic [4:0]  l1_pend_waddr, l1_out_rd_waddr;
  logic        l1_out_rd_wena;
  logic [31:0] l1_out_rd_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_rd_waddr(in_rd_waddr), .in_rd_wena(in_rd_wena), .in_rd_wdata(in_rd_wdata),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .pend_valid(pend_valid), .pend_waddr(pend_waddr),
    .out_rd_waddr(out_rd_waddr), .out_rd_wena(out_rd_wena), .out_rd_wdata(out_rd_wdata)
  );

  pipe_wb_arbiter #(.STARVE_LIMIT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .in_rd_waddr(in_rd_waddr), .in_rd_wena(in_rd_wena), .in_rd_wdata(in_rd_wdata),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_ready(l1_mdu_ready), .pipe_stall(l1_pipe_stall),
    .pend_valid(l1_pend_valid), .pend_waddr(l1_pend_waddr),
    .out_rd_waddr(l1_out_rd_waddr), .out_rd_wena(l1_out_rd_wena), .out_rd_wdata(l1_out_rd_wdata)
  );

  // Port and status views packed for compact comparisons.
  wire [37:0] port    = {out_rd_wena, out_rd_waddr, out_rd_wdata};
  wire [37:0] l1_port = {l1_out_rd_wena, l1_out_rd_waddr, l1_out_rd_wdata};
  wire [7:0]  stat    = {mdu_ready, pipe_stall, pend_valid, pend_waddr};
  wire [7:0]  l1_stat = {l1_mdu_ready, l1_pipe_stall, l1_pend_valid, l1_pend_waddr};

  function automatic logic [37:0] pw(input logic e, input logic [4:0] a, input logic [31:0] d);
    return {e, a, d};
  endfunction

  function automatic logic [7:0] st(input logic r, input logic s, input logic p, input logic [4:0] a);
    return {r, s, p, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic e, input logic [4:0] a, input logic [31:0] d);
    in_rd_wena  = e;
    in_rd_waddr = a;
    in_rd_wdata = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v;
    mdu_waddr = a;
    mdu_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe(1'b1, 5'd3, 32'hDEAD);
    mdu(1'b1, 5'd4, 32'hBEEF);
    #2;
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0)) begin
      errors++; $display("FAIL reset_status: got %h want %h", stat, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
    checks++;
    if (port !== pw(1'b0, 5'd0, 32'd0)) begin
      errors++; $display("FAIL reset_port: got %h want %h", port, pw(1'b0, 5'd0, 32'd0));
    end
    step();
    step();
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_idle_drain();
    mdu(1'b1, 5'd5, 32'h1234);
    #1;
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0)) begin
      errors++; $display("FAIL drain_idle_status: got %h want %h", stat, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
    step();
    mdu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (stat !== st(1'b0, 1'b0, 1'b1, 5'd5)) begin
      errors++; $display("FAIL drain_pend_status: got %h want %h", stat, st(1'b0, 1'b0, 1'b1, 5'd5));
    end
    checks++;
    if (port !== pw(1'b1, 5'd5, 32'h1234)) begin
      errors++; $display("FAIL drain_port: got %h want %h", port, pw(1'b1, 5'd5, 32'h1234));
    end
    step();
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0) || out_rd_wena !== 1'b0) begin
      errors++; $display("FAIL drain_back_idle: got %h/%b want %h/0", stat, out_rd_wena, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
  endtask

  task automatic test_starvation();
    mdu(1'b1, 5'd7, 32'h7777);
    step();
    mdu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      pipe(1'b1, 5'(i), 32'h100 + 32'(i));
      #1;
      checks++;
      if (port !== pw(1'b1, 5'(i), 32'h100 + 32'(i)) || pipe_stall !== 1'b0) begin
        errors++; $display("FAIL starve_pass%0d: got %h stall %b want %h stall 0", i, port, pipe_stall, pw(1'b1, 5'(i), 32'h100 + 32'(i)));
      end
      step();
    end
    // Pipe still holds reg 4 while frozen.
    #1;
    checks++;
    if (stat !== st(1'b0, 1'b1, 1'b1, 5'd7)) begin
      errors++; $display("FAIL starve_force_status: got %h want %h", stat, st(1'b0, 1'b1, 1'b1, 5'd7));
    end
    checks++;
    if (port !== pw(1'b1, 5'd7, 32'h7777)) begin
      errors++; $display("FAIL starve_force_port: got %h want %h", port, pw(1'b1, 5'd7, 32'h7777));
    end
    step();
    checks++;
    if (port !== pw(1'b1, 5'd4, 32'h104) || stat !== st(1'b1, 1'b0, 1'b0, 5'd0)) begin
      errors++; $display("FAIL starve_represent: got %h/%h want %h/%h", port, stat, pw(1'b1, 5'd4, 32'h104), st(1'b1, 1'b0, 1'b0, 5'd0));
    end
    pipe(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_kill();
    // Matching address without write enable must not kill: buffer drains.
    mdu(1'b1, 5'd9, 32'hAAAA);
    step();
    mdu(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd9, 32'h5555);
    #1;
    checks++;
    if (port !== pw(1'b1, 5'd9, 32'hAAAA)) begin
      errors++; $display("FAIL kill_noena_drain: got %h want %h", port, pw(1'b1, 5'd9, 32'hAAAA));
    end
    step();
    // Real kill.
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b1, 5'd9, 32'hAAAA);
    step();
    mdu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd9, 32'h5555);
    #1;
    checks++;
    if (port !== pw(1'b1, 5'd9, 32'h5555)) begin
      errors++; $display("FAIL kill_port: got %h want %h", port, pw(1'b1, 5'd9, 32'h5555));
    end
    step();
    pipe(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pend_valid !== 1'b0 || out_rd_wena !== 1'b0) begin
        errors++; $display("FAIL kill_after%0d: got pend %b wena %b want 0 0", i, pend_valid, out_rd_wena);
      end
      step();
    end
  endtask

  task automatic test_zero_reg();
    mdu(1'b1, 5'd0, 32'hCAFE);
    #1;
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++; $display("FAIL zero_mdu_ready: got %b want 1", mdu_ready);
    end
    step();
    mdu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0) || out_rd_wena !== 1'b0) begin
      errors++; $display("FAIL zero_mdu_dropped: got %h/%b want %h/0", stat, out_rd_wena, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
    pipe(1'b1, 5'd0, 32'hF00D);
    #1;
    checks++;
    if (out_rd_wena !== 1'b0) begin
      errors++; $display("FAIL zero_pipe_wena: got %b want 0", out_rd_wena);
    end
    step();
    pipe(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_async_reset();
    mdu(1'b1, 5'd12, 32'hC0C0);
    step();
    mdu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd3, 32'h3333);
    #1;
    checks++;
    if (pend_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre_pend: got %b want 1", pend_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0) || out_rd_wena !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: got %h/%b want %h/0", stat, out_rd_wena, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
    step();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_rd_wena !== 1'b0 || pend_valid !== 1'b0) begin
        errors++; $display("FAIL areset_after%0d: got wena %b pend %b want 0 0", i, out_rd_wena, pend_valid);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    mdu(1'b1, 5'd10, 32'hA1);
    step();
    // MDU presents the next result immediately and holds it.
    mdu(1'b1, 5'd11, 32'hB2);
    #1;
    checks++;
    if (port !== pw(1'b1, 5'd10, 32'hA1) || mdu_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got %h rdy %b want %h rdy 0", port, mdu_ready, pw(1'b1, 5'd10, 32'hA1));
    end
    step();
    #1;
    checks++;
    if (mdu_ready !== 1'b1 || pend_valid !== 1'b0 || out_rd_wena !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got rdy %b pend %b wena %b want 1 0 0", mdu_ready, pend_valid, out_rd_wena);
    end
    step();
    mdu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (port !== pw(1'b1, 5'd11, 32'hB2)) begin
      errors++; $display("FAIL b2b_second: got %h want %h", port, pw(1'b1, 5'd11, 32'hB2));
    end
    step();
    checks++;
    if (stat !== st(1'b1, 1'b0, 1'b0, 5'd0)) begin
      errors++; $display("FAIL b2b_end: got %h want %h", stat, st(1'b1, 1'b0, 1'b0, 5'd0));
    end
  endtask

  task automatic test_limit_one();
    do_reset();
    #1;
    mdu(1'b1, 5'd6, 32'h6666);
    step();
    mdu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd1, 32'h11);
    #1;
    checks++;
    if (l1_port !== pw(1'b1, 5'd1, 32'h11) || l1_pipe_stall !== 1'b0) begin
      errors++; $display("FAIL lim1_pass: got %h stall %b want %h stall 0", l1_port, l1_pipe_stall, pw(1'b1, 5'd1, 32'h11));
    end
    step();
    #1;
    checks++;
    if (l1_stat !== st(1'b0, 1'b1, 1'b1, 5'd6) || l1_port !== pw(1'b1, 5'd6, 32'h6666)) begin
      errors++; $display("FAIL lim1_force: got %h/%h want %h/%h", l1_stat, l1_port, st(1'b0, 1'b1, 1'b1, 5'd6), pw(1'b1, 5'd6, 32'h6666));
    end
    step();
    checks++;
    if (l1_stat !== st(1'b1, 1'b0, 1'b0, 5'd0) || l1_port !== pw(1'b1, 5'd1, 32'h11)) begin
      errors++; $display("FAIL lim1_idle: got %h/%h want %h/%h", l1_stat, l1_port, st(1'b1, 1'b0, 1'b0, 5'd0), pw(1'b1, 5'd1, 32'h11));
    end
    pipe(1'b0, 5'd0, 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    step();
    test_idle_drain();
    test_starvation();
    test_kill();
    test_zero_reg();
    test_async_reset();
    test_back_to_back();
    test_limit_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
